// File: rtl/pkt_buffer_write.sv
// Pairs incoming packet words with their buffer id and writes them into the packet buffer RAM.
// Words and bufids are staged in separate FIFOs so they may arrive in either order.
module pkt_buffer_write #(
    parameter int DATA_FIFO_AW  = 5,
    parameter int BUFID_FIFO_AW = 2,
    parameter int LINE_W        = 7
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic         i_pkt_wr,
    input  logic [133:0] iv_pkt,
    input  logic         i_pkt_bufid_wr,
    input  logic [8:0]   iv_pkt_bufid,
    output logic         o_wr_en,
    output logic [15:0]  ov_waddr,
    output logic [133:0] ov_wdata,
    output logic         o_pkt_done_pulse,
    output logic [8:0]   ov_pkt_done_bufid,
    output logic         o_err_pulse,
    output logic [15:0]  ov_err_cnt,
    output logic [1:0]   pkt_write_state
);
    localparam int DDEPTH = 1 << DATA_FIFO_AW;
    localparam int BDEPTH = 1 << BUFID_FIFO_AW;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_OVERLEN = 2'd2,
        S_DROP    = 2'd3
    } state_t;

    logic [133:0]            dmem [DDEPTH];
    logic [DATA_FIFO_AW-1:0] dwp_q, drp_q;
    logic [DATA_FIFO_AW:0]   dcnt_q;
    logic                    dfull, dempty, dpush, dpop;
    logic [133:0]            drd;

    logic [8:0]               bmem [BDEPTH];
    logic [BUFID_FIFO_AW-1:0] bwp_q, brp_q;
    logic [BUFID_FIFO_AW:0]   bcnt_q;
    logic                     bfull, bempty, bpush, bpop;
    logic [8:0]               brd;

    state_t              state_q, state_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [8:0]          cur_bufid_q, cur_bufid_d;
    logic                once_q, once_d;
    logic                wr_d, done_d, fsm_err, err_d;

    logic         wr_en_q, done_q, err_q;
    logic [15:0]  waddr_q, err_cnt_q;
    logic [133:0] wdata_q;
    logic [8:0]   done_bufid_q;

    // Staging FIFOs: show-ahead reads, a full FIFO still accepts a push when popped that cycle
    assign dfull  = (dcnt_q == DDEPTH[DATA_FIFO_AW:0]);
    assign dempty = (dcnt_q == '0);
    assign dpush  = i_pkt_wr && (!dfull || dpop);
    assign drd    = dmem[drp_q];
    assign bfull  = (bcnt_q == BDEPTH[BUFID_FIFO_AW:0]);
    assign bempty = (bcnt_q == '0);
    assign bpush  = i_pkt_bufid_wr && (!bfull || bpop);
    assign brd    = bmem[brp_q];

    always_ff @(posedge clk_sys) begin
        if (dpush) dmem[dwp_q] <= iv_pkt;
        if (bpush) bmem[bwp_q] <= iv_pkt_bufid;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dwp_q  <= '0;
            drp_q  <= '0;
            dcnt_q <= '0;
            bwp_q  <= '0;
            brp_q  <= '0;
            bcnt_q <= '0;
        end else begin
            if (dpush) dwp_q <= dwp_q + 1'b1;
            if (dpop)  drp_q <= drp_q + 1'b1;
            dcnt_q <= dcnt_q + {{DATA_FIFO_AW{1'b0}}, dpush} - {{DATA_FIFO_AW{1'b0}}, dpop};
            if (bpush) bwp_q <= bwp_q + 1'b1;
            if (bpop)  brp_q <= brp_q + 1'b1;
            bcnt_q <= bcnt_q + {{BUFID_FIFO_AW{1'b0}}, bpush} - {{BUFID_FIFO_AW{1'b0}}, bpop};
        end
    end

    // A head word seen past line 0 means the previous packet lost its tail
    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        cur_bufid_d = cur_bufid_q;
        once_d      = once_q;
        dpop        = 1'b0;
        bpop        = 1'b0;
        wr_d        = 1'b0;
        done_d      = 1'b0;
        fsm_err     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!dempty) begin
                    if (!drd[133]) begin
                        state_d = S_DROP;
                        once_d  = 1'b0;
                    end else if (!bempty) begin
                        bpop        = 1'b1;
                        cur_bufid_d = brd;
                        line_d      = '0;
                        state_d     = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (!dempty) begin
                    if (drd[133] && line_q != '0) begin
                        fsm_err = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        dpop   = 1'b1;
                        wr_d   = 1'b1;
                        line_d = line_q + {{(LINE_W-1){1'b0}}, 1'b1};
                        if (drd[132]) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else if (&line_q) begin
                            state_d = S_OVERLEN;
                            once_d  = 1'b0;
                        end
                    end
                end
            end
            S_OVERLEN: begin
                if (!dempty) begin
                    if (drd[133]) begin
                        state_d = S_IDLE;
                    end else begin
                        dpop    = 1'b1;
                        fsm_err = !once_q;
                        once_d  = 1'b1;
                        if (drd[132]) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_DROP: begin
                if (dempty || drd[133]) begin
                    state_d = S_IDLE;
                end else begin
                    dpop    = 1'b1;
                    fsm_err = !once_q;
                    once_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign err_d = (i_pkt_wr && !dpush) || (i_pkt_bufid_wr && !bpush) || fsm_err;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            line_q       <= '0;
            cur_bufid_q  <= '0;
            once_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            done_q       <= 1'b0;
            done_bufid_q <= '0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            cur_bufid_q <= cur_bufid_d;
            once_q      <= once_d;
            wr_en_q     <= wr_d;
            done_q      <= done_d;
            err_q       <= err_d;
            if (wr_d) begin
                waddr_q <= 16'({cur_bufid_q, line_q});
                wdata_q <= drd;
            end
            if (done_d) done_bufid_q <= cur_bufid_q;
            if (err_d && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign o_wr_en           = wr_en_q;
    assign ov_waddr          = waddr_q;
    assign ov_wdata          = wdata_q;
    assign o_pkt_done_pulse  = done_q;
    assign ov_pkt_done_bufid = done_bufid_q;
    assign o_err_pulse       = err_q;
    assign ov_err_cnt        = err_cnt_q;
    assign pkt_write_state   = state_q;
endmodule

// File: tb/tb_pkt_buffer_write.sv
// Scoreboard bench for pkt_buffer_write: a packet-level model queues expected RAM writes
// and done pulses, and a monitor compares them as the DUT produces them.
module tb_pkt_buffer_write;
    logic         clk_sys = 1'b0;
    logic         reset_n = 1'b0;
    logic         i_pkt_wr = 1'b0;
    logic [133:0] iv_pkt = '0;
    logic         i_pkt_bufid_wr = 1'b0;
    logic [8:0]   iv_pkt_bufid = '0;
    logic         o_wr_en;
    logic [15:0]  ov_waddr;
    logic [133:0] ov_wdata;
    logic         o_pkt_done_pulse;
    logic [8:0]   ov_pkt_done_bufid;
    logic         o_err_pulse;
    logic [15:0]  ov_err_cnt;
    logic [1:0]   pkt_write_state;

    pkt_buffer_write dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .i_pkt_wr(i_pkt_wr), .iv_pkt(iv_pkt),
        .i_pkt_bufid_wr(i_pkt_bufid_wr), .iv_pkt_bufid(iv_pkt_bufid),
        .o_wr_en(o_wr_en), .ov_waddr(ov_waddr), .ov_wdata(ov_wdata),
        .o_pkt_done_pulse(o_pkt_done_pulse), .ov_pkt_done_bufid(ov_pkt_done_bufid),
        .o_err_pulse(o_err_pulse), .ov_err_cnt(ov_err_cnt),
        .pkt_write_state(pkt_write_state)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic         wr;
        logic [15:0]  addr;
        logic [133:0] data;
        logic         done;
        logic [8:0]   bid;
    } exp_t;

    exp_t         sbq[$];
    logic [133:0] pw[$];
    int checks = 0, fails = 0;
    int err_exp = 0, err_seen = 0;
    int cyc_cnt = 0, push_cyc = 0, lat_cyc = 0;
    bit lat_arm = 0;

    always @(posedge clk_sys) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (o_err_pulse) err_seen++;
            if (o_wr_en || o_pkt_done_pulse) begin
                exp_t e;
                if (lat_arm && o_wr_en) begin
                    lat_cyc = cyc_cnt;
                    lat_arm = 0;
                end
                checks++;
                if (sbq.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected got wr=%0d addr=%h done=%0d bid=%h, none expected",
                             o_wr_en, ov_waddr, o_pkt_done_pulse, ov_pkt_done_bufid);
                end else begin
                    e = sbq.pop_front();
                    if (o_wr_en != e.wr || (e.wr && (ov_waddr != e.addr || ov_wdata != e.data)) ||
                        o_pkt_done_pulse != e.done || (e.done && ov_pkt_done_bufid != e.bid)) begin
                        fails++;
                        $display("FAIL sb_event got wr=%0d addr=%h data_lo=%h done=%0d bid=%h exp wr=%0d addr=%h data_lo=%h done=%0d bid=%h",
                                 o_wr_en, ov_waddr, ov_wdata[31:0], o_pkt_done_pulse, ov_pkt_done_bufid,
                                 e.wr, e.addr, e.data[31:0], e.done, e.bid);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic cyc(input logic pwr, input logic [133:0] p, input logic bwr, input logic [8:0] b);
        i_pkt_wr = pwr; iv_pkt = p; i_pkt_bufid_wr = bwr; iv_pkt_bufid = b;
        @(posedge clk_sys); #1;
        i_pkt_wr = 1'b0; i_pkt_bufid_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0, 1'b0, '0);
    endtask

    function automatic logic [133:0] rnd_word(input logic head, input logic tail);
        logic [127:0] d;
        logic [3:0]   ivc;
        d   = {$urandom(), $urandom(), $urandom(), $urandom()};
        ivc = 4'($urandom_range(0, 15));
        return {head, tail, ivc, d};
    endfunction

    task automatic build(input int len);
        pw.delete();
        for (int i = 0; i < len; i++) pw.push_back(rnd_word(i == 0, i == len - 1));
    endtask

    // Packet-level model: line i goes to bid*128+i, lines past 128 are dropped with one error
    task automatic model_packet(input logic [8:0] bid);
        exp_t e;
        int   n = pw.size();
        for (int i = 0; i < n; i++) begin
            if (i < 128) begin
                e.wr = 1'b1; e.addr = 16'(int'(bid) * 128 + i); e.data = pw[i];
                e.done = (i == n - 1); e.bid = bid;
                sbq.push_back(e);
            end else if (i == n - 1) begin
                e = '0; e.done = 1'b1; e.bid = bid;
                sbq.push_back(e);
            end
        end
        if (n > 128) err_exp++;
    endtask

    task automatic drive_packet(input logic [8:0] bid, input int bpos, input bit gaps);
        if (bpos < 0) cyc(1'b0, '0, 1'b1, bid);
        for (int i = 0; i < pw.size(); i++) begin
            if (gaps) idle($urandom_range(0, 2));
            cyc(1'b1, pw[i], i == bpos, bid);
        end
    endtask

    task automatic send_orphans(input int n);
        err_exp++;
        for (int i = 0; i < n; i++) cyc(1'b1, rnd_word(1'b0, 1'($urandom_range(0, 1))), 1'b0, '0);
    endtask

    task automatic settle(input string nm);
        int k = 0;
        while (sbq.size() != 0 && k < 3000) begin
            @(posedge clk_sys);
            k++;
        end
        #1;
        idle(5);
        chk({nm, "_drained"}, sbq.size(), 0);
        chk({nm, "_err_cnt"}, ov_err_cnt, err_exp);
        chk({nm, "_err_pulses"}, err_seen, err_exp);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_wr_en"}, o_wr_en, 0);
        chk({nm, "_waddr"}, ov_waddr, 0);
        chk({nm, "_wdata"}, {63'd0, |ov_wdata}, 0);
        chk({nm, "_done"}, o_pkt_done_pulse, 0);
        chk({nm, "_done_bid"}, ov_pkt_done_bufid, 0);
        chk({nm, "_err"}, o_err_pulse, 0);
        chk({nm, "_err_cnt"}, ov_err_cnt, 0);
        chk({nm, "_state"}, pkt_write_state, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk_sys);
        #1;
        chk_reset("rst");
        reset_n = 1'b1;
        idle(2);

        // 1: bufid first, then a 4-word packet
        build(4); model_packet(9'h005); drive_packet(9'h005, -1, 0);
        settle("t1");

        // 2: words first, bufid five cycles later
        build(3); model_packet(9'h1FF);
        for (int i = 0; i < 3; i++) cyc(1'b1, pw[i], 1'b0, '0);
        idle(5);
        push_cyc = cyc_cnt + 1;
        lat_arm  = 1;
        cyc(1'b0, '0, 1'b1, 9'h1FF);
        settle("t2");
        chk("t2_latency", lat_cyc - push_cyc, 2);

        // 3: fill the data FIFO, overflow with a 33rd word, then release with a bufid
        build(32); model_packet(9'h0AA);
        for (int i = 0; i < 32; i++) cyc(1'b1, pw[i], 1'b0, '0);
        err_exp++;
        cyc(1'b1, rnd_word(1'b0, 1'b0), 1'b0, '0);
        chk("t3_err_pulse", o_err_pulse, 1);
        chk("t3_err_cnt_now", ov_err_cnt, err_exp);
        cyc(1'b0, '0, 1'b1, 9'h0AA);
        settle("t3");

        // 4: over-length packet
        build(130); model_packet(9'h002); drive_packet(9'h002, -1, 0);
        settle("t4");

        // 5: orphan words before a single-word packet
        send_orphans(2);
        build(1); model_packet(9'h003); drive_packet(9'h003, -1, 0);
        settle("t5");

        // Randomized well-formed traffic with occasional orphan runs
        for (int p = 0; p < 40; p++) begin
            int          len, bpos;
            logic [8:0]  bid;
            if ($urandom_range(0, 5) == 0) send_orphans($urandom_range(1, 3));
            len  = $urandom_range(1, 10);
            bid  = 9'($urandom_range(0, 511));
            bpos = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, len - 1);
            build(len); model_packet(bid); drive_packet(bid, bpos, 1'($urandom_range(0, 1)));
        end
        settle("rand");

        // 6: reset in the middle of a packet whose bufid never arrived
        build(6);
        for (int i = 0; i < 2; i++) cyc(1'b1, pw[i], 1'b0, '0);
        reset_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        chk_reset("t6_rst");
        reset_n  = 1'b1;
        err_exp  = 0;
        err_seen = 0;
        idle(2);
        build(6); model_packet(9'h011); drive_packet(9'h011, -1, 0);
        settle("t6");

        $display("Result: errors=%0d of %0d checks", fails, checks);
        $finish;
    end
endmodule
